// File: rtl/multicycle_adder.sv
// multicycle_adder
// ----------------
// Area-lean adder/subtractor for wide operands. One SLICE-bit full-adder
// slice is reused over N = WIDTH/SLICE clock cycles, least significant slice
// first, with the carry kept in a register between slices.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   start     request a new operation (only looked at while idle)
//   A, B      operands, captured on the accepting edge
//   Cin       carry-in (borrow-in when Sub=1), captured on the accepting edge
//   Sub       0 = add, 1 = subtract, captured on the accepting edge
//   busy      high while an operation is in progress (exactly N cycles)
//   done      one-cycle pulse in the cycle after the result is written
//   Sum       result, held until the next completion
//   Carry     carry-out of the MSB; in subtract mode 1 means "no borrow"
//   Overflow  signed two's-complement overflow of the completed operation
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; results from the previous operation are held
// RUN   | one slice is added per edge; the last slice writes the results

module multicycle_adder #(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Overflow
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (WIDTH < 2 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_params
      $error("multicycle_adder: WIDTH must be >= 2 and an exact multiple of SLICE");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  // Operands are kept in shift registers so the active slice always sits in
  // the low bits; this avoids a variable-index mux across the full width.
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] psum;
  logic [WIDTH-1:0] psum_next;
  logic             carry_q;
  logic [CW-1:0]    cnt;

  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE-1:0] s_sl;
  logic             c_sl;
  logic             c_msb_in;
  logic             accept;
  logic             last;

  assign busy = (state == RUN);
  assign last = (cnt == LAST);

  always_comb begin
    a_sl = a_sh[SLICE-1:0];
    b_sl = b_sh[SLICE-1:0];
    {c_sl, s_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry_q};
    // Carry into the top bit of the slice, recovered from the sum bit itself.
    // On the last slice this is the carry into bit WIDTH-1.
    c_msb_in = s_sl[SLICE-1] ^ a_sl[SLICE-1] ^ b_sl[SLICE-1];
  end

  // Each new slice sum enters at the top of psum and moves down, so after N
  // slices slice 0 lands in the least significant position.
  generate
    if (N == 1) begin : g_psum_single
      assign psum_next = s_sl;
    end else begin : g_psum_shift
      assign psum_next = {s_sl, psum[WIDTH-1:SLICE]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      psum     <= '0;
      carry_q  <= 1'b0;
      cnt      <= '0;
      done     <= 1'b0;
      Sum      <= '0;
      Carry    <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        // Subtraction is A + ~B + 1; the borrow-in flips that trailing 1.
        a_sh    <= A;
        b_sh    <= B ^ {WIDTH{Sub}};
        carry_q <= Cin ^ Sub;
        psum    <= '0;
        cnt     <= '0;
      end else if (state == RUN) begin
        a_sh    <= a_sh >> SLICE;
        b_sh    <= b_sh >> SLICE;
        carry_q <= c_sl;
        psum    <= psum_next;
        cnt     <= cnt + 1'b1;
        if (last) begin
          Sum      <= psum_next;
          Carry    <= c_sl;
          Overflow <= c_msb_in ^ c_sl;
          done     <= 1'b1;
        end
      end
    end
  end

endmodule
